// File: rtl/count_stream_checker.sv
// count_stream_checker: recovers direction, wrap and illegal steps from a counter's output stream.
// Optional statistics counters are built only when COUNT_CHECK_STATS_EN is defined.
module count_stream_checker #(
  parameter int WIDTH = 10,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_valid,
  output logic             locked,
  output logic             dir,
  output logic             dir_chg,
  output logic             wrap,
  output logic             err,
  output logic [ERRW-1:0]  err_count,
  output logic [ERRW-1:0]  wrap_count
);
  typedef enum logic [1:0] {EMPTY, FIRST, LOCKED} state_t;
  state_t state_q;
  logic [WIDTH-1:0] prev_q, delta;
  logic locked_q, dir_q, dir_chg_q, wrap_q, err_q;
  logic step_up, step_dn, legal, cmp, err_d, wrap_d, dir_chg_d;
  always_comb begin
    delta     = cnt_in - prev_q;
    step_up   = delta == WIDTH'(1);
    step_dn   = &delta;
    legal     = step_up | step_dn;
    cmp       = cnt_valid && state_q != EMPTY;
    err_d     = cmp && !legal;
    wrap_d    = cmp && ((step_up && cnt_in == '0) || (step_dn && &cnt_in));
    dir_chg_d = cmp && legal && state_q == LOCKED && step_up != dir_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      prev_q    <= '0;
      locked_q  <= 1'b0;
      dir_q     <= 1'b1;
      dir_chg_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      dir_chg_q <= dir_chg_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      if (cnt_valid) begin
        prev_q <= cnt_in;
        if (state_q == EMPTY) state_q <= FIRST;
        else if (legal) begin
          state_q  <= LOCKED;
          locked_q <= 1'b1;
          dir_q    <= step_up;
        end else begin
          state_q  <= FIRST;
          locked_q <= 1'b0;
        end
      end
    end
  end
`ifdef COUNT_CHECK_STATS_EN
  logic [ERRW-1:0] err_count_q, wrap_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      if (err_d && !(&err_count_q)) err_count_q <= err_count_q + 1'b1;
      if (wrap_d && !(&wrap_count_q)) wrap_count_q <= wrap_count_q + 1'b1;
    end
  end
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;
`else
  assign err_count  = '0;
  assign wrap_count = '0;
`endif
  assign locked  = locked_q;
  assign dir     = dir_q;
  assign dir_chg = dir_chg_q;
  assign wrap    = wrap_q;
  assign err     = err_q;
endmodule

// File: tb/tb_count_stream_checker.sv
// tb_count_stream_checker: randomized stream against a sample-level reference model, plus literal pins.
module tb_count_stream_checker;
`ifdef COUNT_CHECK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, cnt_valid = 1'b0;
  logic [9:0] cnt_in = '0;
  logic locked, dir, dir_chg, wrap, err;
  logic [7:0] err_count, wrap_count;
  int n_vec = 0, n_err = 0;
  bit run = 1'b0;
  int m_state = 0;
  int m_prev = 0, m_errc = 0, m_wrapc = 0;
  bit m_dir = 1'b1, e_chg = 1'b0, e_wrap = 1'b0, e_err = 1'b0;

  count_stream_checker #(.WIDTH(10), .ERRW(8)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .locked(locked), .dir(dir), .dir_chg(dir_chg), .wrap(wrap), .err(err),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", n, $time, act, exp);
    end
  endtask

  // Reference: one call per clock, state described as "no ref / ref only / locked".
  function automatic void model(input bit r, input bit v, input int x);
    int d;
    bit up;
    e_chg = 1'b0; e_wrap = 1'b0; e_err = 1'b0;
    if (r) begin
      m_state = 0; m_prev = 0; m_dir = 1'b1; m_errc = 0; m_wrapc = 0;
      return;
    end
    if (!v) return;
    if (m_state == 0) begin
      m_prev = x; m_state = 1;
      return;
    end
    d = (x - m_prev + 1024) % 1024;
    if (d == 1 || d == 1023) begin
      up = (d == 1);
      e_wrap = up ? (m_prev == 1023) : (m_prev == 0);
      e_chg = (m_state == 2) && (up != m_dir);
      m_dir = up;
      m_state = 2;
      if (e_wrap && m_wrapc < 255) m_wrapc++;
    end else begin
      e_err = 1'b1;
      m_state = 1;
      if (m_errc < 255) m_errc++;
    end
    m_prev = x;
  endfunction

  always @(negedge clk) if (run) begin
    chk("locked", int'(locked), int'(m_state == 2));
    chk("dir", int'(dir), int'(m_dir));
    chk("dir_chg", int'(dir_chg), int'(e_chg));
    chk("wrap", int'(wrap), int'(e_wrap));
    chk("err", int'(err), int'(e_err));
    chk("err_count", int'(err_count), STATS ? m_errc : 0);
    chk("wrap_count", int'(wrap_count), STATS ? m_wrapc : 0);
  end

  task automatic step(input bit r, input bit v, input logic [9:0] x);
    rst = r; cnt_valid = v; cnt_in = x;
    @(posedge clk);
    model(r, v, int'(x));
    @(negedge clk);
  endtask

  initial begin
    bit [9:0] cur;
    bit up;
    int r;
    @(negedge clk);
    step(1'b1, 1'b0, 10'h0);
    run = 1'b1;
    step(1'b1, 1'b0, 10'h0);
    chk("lit_rst_locked", int'(locked), 0);
    chk("lit_rst_dir", int'(dir), 1);
    chk("lit_rst_errc", int'(err_count), 0);
    step(1'b0, 1'b1, 10'h3FC);
    step(1'b0, 1'b1, 10'h3FD);
    chk("lit_lock_locked", int'(locked), 1);
    chk("lit_lock_dir", int'(dir), 1);
    step(1'b0, 1'b1, 10'h3FE);
    step(1'b0, 1'b1, 10'h3FF);
    chk("lit_prewrap", int'(wrap), 0);
    step(1'b0, 1'b1, 10'h000);
    chk("lit_wrap", int'(wrap), 1);
    chk("lit_wrap_count", int'(wrap_count), STATS ? 1 : 0);
    step(1'b0, 1'b1, 10'h001);
    chk("lit_wrap_once", int'(wrap), 0);
    chk("lit_wrap_dir", int'(dir), 1);
    step(1'b1, 1'b0, 10'h0);
    step(1'b0, 1'b1, 10'h10D);
    step(1'b0, 1'b1, 10'h10E);
    step(1'b0, 1'b1, 10'h10D);
    chk("lit_chg", int'(dir_chg), 1);
    chk("lit_chg_dir", int'(dir), 0);
    step(1'b0, 1'b1, 10'h10C);
    chk("lit_chg_once", int'(dir_chg), 0);
    chk("lit_chg_noerr", int'(err), 0);
    step(1'b1, 1'b0, 10'h0);
    step(1'b0, 1'b1, 10'h0F1);
    step(1'b0, 1'b1, 10'h0F0);
    step(1'b0, 1'b1, 10'h000);
    chk("lit_jump_err", int'(err), 1);
    chk("lit_jump_unlock", int'(locked), 0);
    step(1'b0, 1'b1, 10'h3FF);
    chk("lit_resync_locked", int'(locked), 1);
    chk("lit_resync_dir", int'(dir), 0);
    chk("lit_resync_wrap", int'(wrap), 1);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 10'h3FF);
    chk("lit_sat_err", int'(err), 1);
    chk("lit_sat_count", int'(err_count), STATS ? 255 : 0);
    step(1'b0, 1'b1, 10'h005);
    step(1'b0, 1'b1, 10'h006);
    step(1'b1, 1'b1, 10'h007);
    chk("lit_rst_mid_locked", int'(locked), 0);
    chk("lit_rst_mid_err", int'(err) + int'(wrap) + int'(dir_chg), 0);
    chk("lit_rst_mid_errc", int'(err_count), 0);
    step(1'b0, 1'b1, 10'h008);
    step(1'b0, 1'b1, 10'h009);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 10'h100);
    step(1'b0, 1'b1, 10'h00A);
    chk("lit_gap_noerr", int'(err), 0);
    chk("lit_gap_locked", int'(locked), 1);
    cur = 10'h00A;
    up = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(99));
      if (r < 2) step(1'b1, 1'b1, cur);
      else if (r < 10) step(1'b0, 1'b0, 10'($urandom));
      else if (r < 14) begin
        cur = r[0] ? 10'($urandom) : 10'(1020 + $urandom_range(7));
        step(1'b0, 1'b1, cur);
      end else if (r < 16) step(1'b0, 1'b1, cur);
      else begin
        if ($urandom_range(9) == 0) up = !up;
        cur = up ? cur + 10'd1 : cur - 10'd1;
        step(1'b0, 1'b1, cur);
      end
    end
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
